// File: rtl/acc_pkg.sv
// Shared encodings for the accumulator CPU: opcodes, control FSM states and
// the ALU / PC / operand-select codes that the datapath and PC also decode.
package acc_pkg;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_AND   = 5'b00010;
  localparam logic [4:0] OP_OR    = 5'b00011;
  localparam logic [4:0] OP_LOAD  = 5'b00100;
  localparam logic [4:0] OP_STORE = 5'b00101;
  localparam logic [4:0] OP_ADDI  = 5'b00110;
  localparam logic [4:0] OP_BEQ   = 5'b01000;
  localparam logic [4:0] OP_BNE   = 5'b01001;
  localparam logic [4:0] OP_J     = 5'b01010;
  localparam logic [4:0] OP_JR    = 5'b01100;
  localparam logic [4:0] OP_HALT  = 5'b11111;

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADDR = 4'd3,
    S_MEMRD   = 4'd4,
    S_WB_MEM  = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_WB_ALU  = 4'd8,
    S_MEMWR   = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_JUMPR_A = 4'd12,
    S_JUMPR_W = 4'd13,
    S_HALT    = 4'd14
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'b000,
    ALU_SUB    = 3'b001,
    ALU_AND    = 3'b010,
    ALU_OR     = 3'b011,
    ALU_PASS_A = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_PLUS2  = 2'b00,
    PC_JUMP   = 2'b01,
    PC_ALUOUT = 2'b10,
    PC_ZERO   = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    SRCB_MEM     = 2'b00,
    SRCB_TWO     = 2'b01,
    SRCB_OFFS_SH = 2'b10,
    SRCB_IMM     = 2'b11
  } alu_srcb_e;

  typedef struct packed {
    logic      pc_write;
    logic      branch;
    logic      bne_or_beq;
    pc_src_e   pc_src;
    logic      ir_write;
    logic      mem_read;
    logic      mem_write;
    logic      i_or_d;
    logic      acc_write;
    logic      mem_to_acc;
    logic      alu_src_a;
    alu_srcb_e alu_src_b;
    alu_op_e   alu_op;
    logic      halted;
  } ctrl_t;

endpackage

// File: rtl/acc_ctrl_decode.sv
// State-to-control-word decode; depends only on registered state so the
// control outputs have no combinational path from Opcode.
module acc_ctrl_decode
  import acc_pkg::*;
(
  input  state_e     state_i,
  input  logic [1:0] op_lo_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.alu_src_b = SRCB_TWO;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_src    = PC_PLUS2;
        ctrl_o.pc_write  = 1'b1;
      end
      S_DECODE:  ctrl_o.alu_src_b = SRCB_OFFS_SH;
      // absolute operand address: datapath forces A so ALUOut = ZE(IR[10:0])
      S_MEMADDR: ctrl_o.alu_src_b = SRCB_IMM;
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_WB_MEM: begin
        ctrl_o.acc_write  = 1'b1;
        ctrl_o.mem_to_acc = 1'b1;
      end
      S_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_MEM;
        ctrl_o.alu_op    = alu_op_e'({1'b0, op_lo_i});
      end
      S_EXEC_I: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_WB_ALU: ctrl_o.acc_write = 1'b1;
      S_MEMWR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_op     = ALU_PASS_A;
        ctrl_o.branch     = 1'b1;
        ctrl_o.pc_src     = PC_ALUOUT;
        ctrl_o.bne_or_beq = ~op_lo_i[0];
      end
      S_JUMP: begin
        ctrl_o.pc_src   = PC_JUMP;
        ctrl_o.pc_write = 1'b1;
      end
      S_JUMPR_A: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALU_PASS_A;
      end
      S_JUMPR_W: begin
        ctrl_o.pc_src   = PC_ALUOUT;
        ctrl_o.pc_write = 1'b1;
      end
      S_HALT:  ctrl_o.halted = 1'b1;
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/accumulator_control.sv
// Multicycle Moore control FSM for the accumulator CPU: state register,
// next-state logic and the opcode bits needed by EXEC_R / BRANCH.
module accumulator_control
  import acc_pkg::*;
(
  input  logic       CLK,
  input  logic       reset,
  input  logic [4:0] Opcode,
  output logic       PCWrite,
  output logic       Branch,
  output logic       bneOrbeq,
  output logic [1:0] PCSrc,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       AccWrite,
  output logic       MemtoAcc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       Halted
);

  state_e     state_q, state_d;
  logic [1:0] op_lo_q;
  ctrl_t      ctrl;

  always_comb begin
    state_d = S_RESET;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_LOAD, OP_STORE: state_d = S_MEMADDR;
          OP_ADDI:           state_d = S_EXEC_I;
          OP_BEQ, OP_BNE:    state_d = S_BRANCH;
          OP_J:              state_d = S_JUMP;
          OP_JR:             state_d = S_JUMPR_A;
          OP_HALT:           state_d = S_HALT;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADDR: state_d = (Opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = (Opcode == OP_LOAD) ? S_WB_MEM : S_EXEC_R;
      S_WB_MEM,
      S_WB_ALU,
      S_MEMWR,
      S_BRANCH,
      S_JUMP,
      S_JUMPR_W: state_d = S_FETCH;
      S_EXEC_R,
      S_EXEC_I:  state_d = S_WB_ALU;
      S_JUMPR_A: state_d = S_JUMPR_W;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_RESET;
    endcase
  end

  // ALU-op and branch polarity come from Opcode[1:0]; capture them in DECODE
  // so the control word stays a pure function of registered state.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_RESET;
      op_lo_q <= 2'b00;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_lo_q <= Opcode[1:0];
    end
  end

  acc_ctrl_decode u_decode (
    .state_i (state_q),
    .op_lo_i (op_lo_q),
    .ctrl_o  (ctrl)
  );

  assign PCWrite  = ctrl.pc_write;
  assign Branch   = ctrl.branch;
  assign bneOrbeq = ctrl.bne_or_beq;
  assign PCSrc    = ctrl.pc_src;
  assign IRWrite  = ctrl.ir_write;
  assign MemRead  = ctrl.mem_read;
  assign MemWrite = ctrl.mem_write;
  assign IorD     = ctrl.i_or_d;
  assign AccWrite = ctrl.acc_write;
  assign MemtoAcc = ctrl.mem_to_acc;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign ALUOp    = ctrl.alu_op;
  assign Halted   = ctrl.halted;

endmodule

// File: doc/accumulator_control.md
# accumulator_control

Multicycle control unit for the accumulator CPU: a Moore state machine that decodes the 5-bit opcode from the instruction register and sequences fetch, decode, execute, memory and write-back. It is the driving end of the program-counter interface, producing PCWrite, Branch, bneOrbeq and PCSrc. It also drives the IR, memory, accumulator and ALU controls for the datapath.

## Interface
- No parameters. Opcode and state encodings are fixed constants.
- CLK  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high; forces state RESET
- Opcode  in  5  IR[15:11], valid from DECODE onward
- PCWrite  out  1  unconditional PC load
- Branch  out  1  conditional PC load, qualified by Zero inside the PC
- bneOrbeq  out  1  1 = load on Zero (BEQ), 0 = load on ~Zero (BNE)
- PCSrc  out  2  00 PC+2 (ALU), 01 jump target {IR[10:0]} ZE<<1, 10 ALUOut, 11 16'h0000
- IRWrite  out  1  latch memory data into IR
- MemRead / MemWrite  out  1 each  memory strobes
- IorD  out  1  0 = address from PC, 1 = address from ALUOut
- AccWrite  out  1  accumulator load enable
- MemtoAcc  out  1  1 = accumulator takes memory data, 0 = ALUOut
- ALUSrcA  out  1  0 = PC, 1 = accumulator
- ALUSrcB  out  2  00 memory data, 01 const 2, 10 ZE(IR[10:0])<<1, 11 ZE(IR[10:0])
- ALUOp  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 PASS_A
- Halted  out  1  high while in HALT

## Operation
- Opcodes: ADD 00000, SUB 00001, AND 00010, OR 00011, LOAD 00100, STORE 00101, ADDI 00110, BEQ 01000, BNE 01001, J 01010, JR 01100, HALT 11111. Every other opcode is a NOP.
- RESET: all outputs 0. Next state is FETCH.
- FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSrc=00, PCWrite=1. Next state is DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=ADD, which places the branch target in ALUOut. Next state by opcode:
  - ADD/SUB/AND/OR go to MEMADDR.
  - LOAD/STORE go to MEMADDR.
  - ADDI goes to EXEC_I.
  - BEQ/BNE go to BRANCH.
  - J goes to JUMP.
  - JR goes to JUMPR.
  - HALT goes to HALT.
  - NOP goes to FETCH.
- MEMADDR: ALUSrcA=0, ALUSrcB=11, ALUOp=PASS_B semantics via ADD with A forced by datapath. Because the address is an absolute operand, ALUOut holds ZE(IR[10:0]). Next state:
  - LOAD/ALU ops go to MEMRD.
  - STORE goes to MEMWR.
- MEMRD: MemRead=1, IorD=1. Next state:
  - LOAD goes to WB_MEM.
  - ALU ops go to EXEC_R.
- WB_MEM: AccWrite=1, MemtoAcc=1. Next state is FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp from opcode[1:0]. Next state is WB_ALU.
- EXEC_I: ALUSrcA=1, ALUSrcB=11, ALUOp=ADD. Next state is WB_ALU.
- WB_ALU: AccWrite=1, MemtoAcc=0. Next state is FETCH.
- MEMWR: MemWrite=1, IorD=1. Next state is FETCH.
- BRANCH: ALUSrcA=1, ALUOp=PASS_A so that Zero reflects Acc==0. Branch=1, PCSrc=10, bneOrbeq=~Opcode[0]. Next state is FETCH.
- JUMP: PCSrc=01, PCWrite=1. Next state is FETCH.
- JUMPR: ALUSrcA=1, ALUOp=PASS_A, PCSrc=10, PCWrite=1. ALUOut is not yet valid in this cycle, so JUMPR takes 2 cycles: JUMPR_A computes, JUMPR_W writes. Next state is FETCH.
- HALT: Halted=1, all other outputs 0. The FSM stays in HALT until reset.
- Any output not listed for a state is 0.
- Unreachable state encodings go to RESET on the next edge.

## Timing
- Outputs are purely a decode of the registered state, so there is no input-to-output combinational path.
- Opcode is sampled only in DECODE, MEMADDR, MEMRD and BRANCH. IR is stable there because IRWrite is asserted only in FETCH.
- Cycles per instruction:
  - NOP: 2
  - J, HALT entry: 3
  - BEQ/BNE: 3
  - ADDI, STORE: 4
  - JR: 4
  - LOAD: 5
  - ADD/SUB/AND/OR: 6
- reset takes priority over every state, including mid-instruction and HALT. The next state is RESET and outputs are 0 in the following cycle. An in-flight store is aborted if reset arrives before MEMWR.
- Exactly one of PCWrite or Branch is high in any cycle, or neither.

## Structure
- Shared package `acc_pkg`:
  - opcode constants
  - state enum (4-bit)
  - ALUOp, PCSrc and ALUSrcB encodings, which are reused by the datapath and the PC.
- One sub-module, `acc_ctrl_decode`: combinational state-to-control-word decode.
- The top level holds the state register and the next-state logic.

## Test plan
- Reset: assert reset for 2 cycles, then release. Required: all outputs 0 in RESET, FETCH asserted one cycle later with PCWrite=1, PCSrc=00, IRWrite=1.
- LOAD (00100): required state sequence FETCH→DECODE→MEMADDR→MEMRD→WB_MEM→FETCH. AccWrite=1 with MemtoAcc=1 only in WB_MEM.
- BEQ (01000), then BNE (01001): in the BRANCH cycle, Branch=1, PCSrc=10, PCWrite=0. bneOrbeq=1 for BEQ and 0 for BNE.
- J (01010): PCWrite=1 with PCSrc=01 in cycle 3, then back to FETCH. JR (01100): PCWrite=1 with PCSrc=10 in cycle 4.
- HALT (11111): Halted stays 1 for 20 cycles with PCWrite=0. Reset then returns to RESET→FETCH.
- Undefined opcode 10101 returns to FETCH after DECODE with no write strobes. Reset asserted during MEMRD of an ADD gives RESET on the next cycle with AccWrite never asserted.
